// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad serial transmit path.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [7:0] ASCII_NONE = 8'h00;

  function automatic int baud_div(int clk, int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_uart_tx.sv
// Queues one ASCII byte per key press and serialises each as a UART 8N1 frame.
module keypad_uart_tx
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned DIVISOR = 32'(baud_div(int'(CLK_FREQ), int'(BAUD)));
  localparam int unsigned BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          start_q;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          baud_end;
  logic          idle_next;
  logic          busy_next;
  logic [7:0]    fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Fullness is judged on the pre-pop count, so a full FIFO drops even while popping.
  assign push_req = start && !start_q && (data != ASCII_NONE);
  assign push     = push_req && !fifo_full;
  assign baud_end = (baud_cnt == BW'(DIVISOR - 1));
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));

  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign idle_next  = fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
  assign busy_next  = !idle_next || (count_next != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      start_q  <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      start_q  <= start;
      overflow <= push_req && fifo_full;
      busy     <= busy_next;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (pop) begin
            shift <= fifo_rd_data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when another byte is queued.
            if (pop) begin
              shift <= fifo_rd_data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
